bcd_seq_converter: RTL

Parametrised multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble), one shift per clock, with valid/ready handshakes on both sides and a leading-zero blanking mask. It sits between score/counter logic and the seven-segment display drivers. It replaces the fixed 8-bit, whole-conversion-per-cycle converter with a narrow iterative datapath that scales to wide inputs.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_add3_cell.sv | 11 +
 rtl/bcd_seq_converter.sv | 101 ++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the iterative binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic logic [3:0] bcd_add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // 2^W-1 has as many decimal digits as 2^W (no power of two is a power of ten).
  function automatic int bcd_digits_needed(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Per-digit double-dabble correction: add 3 to a BCD field holding 5 or more.
module bcd_add3_cell
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = bcd_add3(din);

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-cycle binary-to-BCD converter, one double-dabble shift per clock,
// with valid/ready on both sides and leading-zero blanking for the display.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      number,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     blank
);

  localparam int WW = 4 * DIGITS + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 1) begin : g_bad_width
    $error("bcd_seq_converter: WIDTH must be at least 1");
  end
  if (DIGITS < bcd_digits_needed(WIDTH)) begin : g_bad_digits
    $error("bcd_seq_converter: DIGITS too small to hold 2^WIDTH-1");
  end

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WW-1:0]   work;
  logic [WW-1:0]   work_adj;
  logic [WW-1:0]   work_next;
  logic            higher_zero;

  // All digit fields are corrected in parallel from the pre-shift value.
  assign work_adj[WIDTH-1:0] = work[WIDTH-1:0];
  for (genvar k = 0; k < DIGITS; k++) begin : g_cell
    bcd_add3_cell u_cell (
      .din  (work[WIDTH+4*k +: 4]),
      .dout (work_adj[WIDTH+4*k +: 4])
    );
  end

  assign work_next = work_adj << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      digits    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= {{(4*DIGITS){1'b0}}, number};
            cnt      <= CW'(WIDTH);
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          work <= work_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            digits    <= work_next[WW-1 -: 4*DIGITS];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // A digit is blanked only if it and every digit above it are zero; ones never blank.
  always_comb begin
    blank       = '0;
    higher_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      higher_zero = higher_zero & (digits[4*k +: 4] == 4'd0);
      blank[k]    = higher_zero;
    end
  end

endmodule
